// File: rtl/bcd_converter_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), start/done handshake.
// Ports: clk, rst (async, active high), start, bin[BIN_W] -> busy, done,
//   bcd[4*DIGITS] (digit k at [4k+3:4k]), overflow, digit_en[DIGITS].
// Optional leading-zero blanking of digit_en: define BCD_LZ_BLANK_EN.
module bcd_converter_seq #(
   parameter int BIN_W  = 7,
   parameter int DIGITS = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [BIN_W-1:0]    bin,
   output logic                busy,
   output logic                done,
   output logic [4*DIGITS-1:0] bcd,
   output logic                overflow,
   output logic [DIGITS-1:0]   digit_en
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(BIN_W);
   localparam logic [CW-1:0] LAST = CW'(BIN_W - 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t            state_q, state_d;
   logic [BIN_W-1:0]  opnd_q, opnd_d;
   logic [BW-1:0]     work_q, work_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              ovf_acc_q, ovf_acc_d;
   logic              done_q, done_d;
   logic [BW-1:0]     bcd_q, bcd_d;
   logic              ovf_q, ovf_d;

   logic [BW-1:0]     adj;
   logic              big;
   logic              ovf_now;

   // Per-digit add-3 correction; big flags a non-decimal digit.
   always_comb begin
      adj = work_q;
      big = 1'b0;
      for (int k = 0; k < DIGITS; k++) begin
         if (work_q[4*k +: 4] >= 4'd5)
            adj[4*k +: 4] = work_q[4*k +: 4] + 4'd3;
         if (work_q[4*k +: 4] > 4'd9)
            big = 1'b1;
      end
   end

   assign ovf_now = ovf_acc_q | big;

   always_comb begin
      state_d   = state_q;
      opnd_d    = opnd_q;
      work_d    = work_q;
      cnt_d     = cnt_q;
      ovf_acc_d = ovf_acc_q;
      done_d    = 1'b0;
      bcd_d     = bcd_q;
      ovf_d     = ovf_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               opnd_d    = bin;
               work_d    = '0;
               cnt_d     = '0;
               ovf_acc_d = 1'b0;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            // Bit leaving the top digit means the value no longer fits.
            {work_d, opnd_d} = {adj[BW-2:0], opnd_q, 1'b0};
            ovf_acc_d = ovf_acc_q | adj[BW-1];
            cnt_d     = cnt_q + CW'(1);
            if (cnt_q == LAST)
               state_d = DONE;
         end
         DONE: begin
            done_d  = 1'b1;
            ovf_d   = ovf_now;
            bcd_d   = ovf_now ? {DIGITS{4'd9}} : work_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         opnd_q    <= '0;
         work_q    <= '0;
         cnt_q     <= '0;
         ovf_acc_q <= 1'b0;
         done_q    <= 1'b0;
         bcd_q     <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         opnd_q    <= opnd_d;
         work_q    <= work_d;
         cnt_q     <= cnt_d;
         ovf_acc_q <= ovf_acc_d;
         done_q    <= done_d;
         bcd_q     <= bcd_d;
         ovf_q     <= ovf_d;
      end
   end

`ifdef BCD_LZ_BLANK_EN
   logic [DIGITS-1:0] den_q, den_d;
   logic              seen;

   // Enable a digit once any digit at or above it is nonzero.
   always_comb begin
      den_d = den_q;
      seen  = 1'b0;
      if (state_q == DONE) begin
         for (int k = DIGITS - 1; k >= 0; k--) begin
            seen     = seen | (work_q[4*k +: 4] != 4'd0);
            den_d[k] = seen;
         end
         den_d[0] = 1'b1;
         if (ovf_now)
            den_d = '1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         den_q <= '1;
      else
         den_q <= den_d;
   end

   assign digit_en = den_q;
`else
   assign digit_en = '1;
`endif

   assign busy     = (state_q == SHIFT);
   assign done     = done_q;
   assign bcd      = bcd_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_bcd_converter_seq.sv
// Self-checking bench for bcd_converter_seq: three instances
// (7b/3d, 7b/2d sharing stimulus, 10b/4d) against a decimal reference model.
module tb_bcd_converter_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_a = 1'b0;
   logic       start_c = 1'b0;
   logic [6:0] bin_a = '0;
   logic [9:0] bin_c = '0;

   logic        busy_a, done_a, ovf_a;
   logic [11:0] bcd_a;
   logic [2:0]  en_a;
   logic        busy_b, done_b, ovf_b;
   logic [7:0]  bcd_b;
   logic [1:0]  en_b;
   logic        busy_c, done_c, ovf_c;
   logic [15:0] bcd_c;
   logic [3:0]  en_c;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   bcd_converter_seq #(.BIN_W(7), .DIGITS(3)) u_a (
      .clk(clk), .rst(rst), .start(start_a), .bin(bin_a),
      .busy(busy_a), .done(done_a), .bcd(bcd_a),
      .overflow(ovf_a), .digit_en(en_a)
   );

   bcd_converter_seq #(.BIN_W(7), .DIGITS(2)) u_b (
      .clk(clk), .rst(rst), .start(start_a), .bin(bin_a),
      .busy(busy_b), .done(done_b), .bcd(bcd_b),
      .overflow(ovf_b), .digit_en(en_b)
   );

   bcd_converter_seq #(.BIN_W(10), .DIGITS(4)) u_c (
      .clk(clk), .rst(rst), .start(start_c), .bin(bin_c),
      .busy(busy_c), .done(done_c), .bcd(bcd_c),
      .overflow(ovf_c), .digit_en(en_c)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Decimal reference: plain division, saturate to all nines on overflow.
   function automatic void ref_conv(input int v, input int nd,
                                    output logic [31:0] eb,
                                    output logic eo,
                                    output logic [7:0] ee);
      int lim;
      int p;
      lim = 1;
      for (int k = 0; k < nd; k++) lim = lim * 10;
      eo = (v >= lim);
      eb = '0;
      ee = '0;
      p  = 1;
      for (int k = 0; k < nd; k++) begin
         eb[4*k +: 4] = eo ? 4'd9 : 4'((v / p) % 10);
`ifdef BCD_LZ_BLANK_EN
         ee[k] = eo || (k == 0) || (v >= p);
`else
         ee[k] = 1'b1;
`endif
         p = p * 10;
      end
   endfunction

   // Called at a negedge; returns at the negedge where done is seen.
   task automatic run_conv(input int which, input int v, input string tag);
      int e;
      int nbusy;
      int bw;
      logic [31:0] eb;
      logic eo;
      logic [7:0] ee;
      bw = (which == 2) ? 10 : 7;
      if (which == 2) begin
         start_c = 1'b1;
         bin_c   = 10'(v);
      end else begin
         start_a = 1'b1;
         bin_a   = 7'(v);
      end
      @(negedge clk);
      start_a = 1'b0;
      start_c = 1'b0;
      e = 0;
      nbusy = 0;
      chk({tag, "_done0"}, 32'(which == 2 ? done_c : done_a), 0);
      while (!(which == 2 ? done_c : done_a) && e < 40) begin
         if (which == 2 ? busy_c : busy_a) nbusy++;
         @(negedge clk);
         e++;
      end
      chk({tag, "_lat"}, 32'(e), 32'(bw + 1));
      chk({tag, "_busy"}, 32'(nbusy), 32'(bw));
      if (which == 2) begin
         ref_conv(v, 4, eb, eo, ee);
         chk({tag, "_bcd"}, 32'(bcd_c), eb);
         chk({tag, "_ovf"}, 32'(ovf_c), 32'(eo));
         chk({tag, "_en"}, 32'(en_c), 32'(ee[3:0]));
      end else begin
         ref_conv(v, 3, eb, eo, ee);
         chk({tag, "_bcd3"}, 32'(bcd_a), eb);
         chk({tag, "_ovf3"}, 32'(ovf_a), 32'(eo));
         chk({tag, "_en3"}, 32'(en_a), 32'(ee[2:0]));
         ref_conv(v, 2, eb, eo, ee);
         chk({tag, "_done2"}, 32'(done_b), 1);
         chk({tag, "_bcd2"}, 32'(bcd_b), eb);
         chk({tag, "_ovf2"}, 32'(ovf_b), 32'(eo));
         chk({tag, "_en2"}, 32'(en_b), 32'(ee[1:0]));
      end
   endtask

   initial begin
      int v;
      int nd;
      int t[3];
      int rdone;
      logic [15:0] hold;

      @(negedge clk);
      chk("rst_busy", 32'(busy_a), 0);
      chk("rst_done", 32'(done_a), 0);
      chk("rst_bcd", 32'(bcd_a), 0);
      chk("rst_ovf", 32'(ovf_a), 0);
      chk("rst_en", 32'(en_c), 32'hf);
      rst = 1'b0;
      @(negedge clk);

      run_conv(0, 99, "d99");
      @(negedge clk);
      run_conv(0, 127, "d127");
      run_conv(0, 0, "d0_b2b");
      run_conv(0, 42, "d42");
      for (int i = 0; i < 10; i++) begin
         v = int'($urandom_range(0, 127));
         run_conv(0, v, "rnd7");
      end

      // Start held high; bin changes after the first capture.
      start_a = 1'b1;
      bin_a   = 7'd55;
      nd = 0;
      for (int i = 1; i <= 27; i++) begin
         @(negedge clk);
         if (i == 3) bin_a = 7'd10;
         if (done_a) begin
            if (nd < 3) t[nd] = i;
            chk("cont_bcd", 32'(bcd_a), (nd == 0) ? 32'h055 : 32'h010);
            nd++;
         end
      end
      start_a = 1'b0;
      chk("cont_cnt", 32'(nd), 3);
      chk("cont_t0", 32'(t[0]), 9);
      chk("cont_t1", 32'(t[1] - t[0]), 9);
      chk("cont_t2", 32'(t[2] - t[1]), 9);

      // Reset in the middle of a conversion.
      @(negedge clk);
      start_a = 1'b1;
      bin_a   = 7'd88;
      @(negedge clk);
      start_a = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("mrst_busy", 32'(busy_a), 0);
      chk("mrst_bcd", 32'(bcd_a), 0);
      chk("mrst_done", 32'(done_a), 0);
      rst = 1'b0;
      rdone = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done_a) rdone++;
      end
      chk("mrst_nodone", 32'(rdone), 0);
      run_conv(0, 88, "d88");

      // Wide instance.
      @(negedge clk);
      run_conv(2, 7, "w7");
      run_conv(2, 0, "w0");
      run_conv(2, 1023, "w1023");
      run_conv(2, 999, "w999");
      run_conv(2, 100, "w100");
      for (int i = 0; i < 5; i++) begin
         v = int'($urandom_range(0, 1023));
         run_conv(2, v, "rnd10");
      end
      hold = bcd_c;
      repeat (5) @(negedge clk);
      chk("hold_bcd", 32'(bcd_c), 32'(hold));
      chk("hold_done", 32'(done_c), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
